// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled UART receiver (8 data bits, even parity,
// 1 stop bit) feeding a first-word-fall-through receive FIFO.
module uart_rx_fifo #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Rx_EN,
  input  logic       RxD,
  input  logic       Rx_RD,
  output logic [7:0] Rx_DATA,
  output logic       Rx_FERROR,
  output logic       Rx_PERROR,
  output logic       Rx_EMPTY,
  output logic       Rx_FULL,
  output logic       Rx_OVERRUN
);
  localparam int unsigned AW = $clog2(DEPTH);

  function automatic logic [15:0] div_of(input int unsigned baud);
    int unsigned d;
    d = (CLK_HZ + 8 * baud) / (16 * baud);
    if (d == 0) d = 1;
    return d[15:0];
  endfunction

  localparam logic [15:0] DIV_300    = div_of(300);
  localparam logic [15:0] DIV_1200   = div_of(1200);
  localparam logic [15:0] DIV_4800   = div_of(4800);
  localparam logic [15:0] DIV_9600   = div_of(9600);
  localparam logic [15:0] DIV_19200  = div_of(19200);
  localparam logic [15:0] DIV_38400  = div_of(38400);
  localparam logic [15:0] DIV_57600  = div_of(57600);
  localparam logic [15:0] DIV_115200 = div_of(115200);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic        rxd_meta_q, rxd_sync_q, rxd_prev_q;
  state_t      state_q, state_d;
  logic [2:0]  baud_q, baud_d;
  logic [15:0] div_q, div_d, div_val;
  logic [3:0]  tick_q, tick_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        s7_q, s7_d, s8_q, s8_d;
  logic        perr_q, perr_d;
  logic        tick, maj, push, push_ferr;

  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic        empty_q, empty_d, full_q, full_d, ovr_q, ovr_d;
  logic [9:0]  head_q, head_d, push_word;
  logic        pop_ok, push_ok;
  logic [9:0]  mem_q [DEPTH];

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= RxD;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end

  // Divider value for the baud code latched while idle
  always_comb begin
    case (baud_q)
      3'd0:    div_val = DIV_300;
      3'd1:    div_val = DIV_1200;
      3'd2:    div_val = DIV_4800;
      3'd3:    div_val = DIV_9600;
      3'd4:    div_val = DIV_19200;
      3'd5:    div_val = DIV_38400;
      3'd6:    div_val = DIV_57600;
      default: div_val = DIV_115200;
    endcase
  end

  // Receiver state, tick divider and bit assembly registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      div_q   <= '0;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      s7_q    <= 1'b0;
      s8_q    <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      s7_q    <= s7_d;
      s8_q    <= s8_d;
      perr_q  <= perr_d;
    end
  end

  // Next-state logic: majority vote on ticks 7/8/9, state advance on tick 15
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    div_d     = div_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    s7_d      = s7_q;
    s8_d      = s8_q;
    perr_d    = perr_q;
    push      = 1'b0;
    push_ferr = 1'b0;
    tick      = 1'b0;
    maj       = (s7_q & s8_q) | (s7_q & rxd_sync_q) | (s8_q & rxd_sync_q);
    if (state_q == IDLE) begin
      baud_d = baud_select;
      if (Rx_EN && rxd_prev_q && !rxd_sync_q) state_d = START;
    end else begin
      tick  = (div_q == div_val - 16'd1);
      div_d = tick ? '0 : div_q + 16'd1;
      if (tick) begin
        tick_d = tick_q + 4'd1;
        if (tick_q == 4'd7) s7_d = rxd_sync_q;
        if (tick_q == 4'd8) s8_d = rxd_sync_q;
        unique case (state_q)
          START: begin
            if (tick_q == 4'd9 && maj) state_d = IDLE;
            else if (tick_q == 4'd15) state_d = DATA;
          end
          DATA: begin
            if (tick_q == 4'd9) shift_d = {maj, shift_q[7:1]};
            if (tick_q == 4'd15) begin
              bit_d = bit_q + 3'd1;
              if (bit_q == 3'd7) state_d = PARITY;
            end
          end
          PARITY: begin
            if (tick_q == 4'd9) perr_d = (^shift_q) ^ maj;
            if (tick_q == 4'd15) state_d = STOP;
          end
          STOP: begin
            if (tick_q == 4'd9) begin
              push      = 1'b1;
              push_ferr = !maj;
              state_d   = IDLE;
            end
          end
          default: ;
        endcase
      end
      if (!Rx_EN) begin
        state_d = IDLE;
        push    = 1'b0;
      end
    end
    if (state_d == IDLE) begin
      div_d  = '0;
      tick_d = '0;
      bit_d  = '0;
    end
  end

  // FIFO pointer/flag update; head register is preloaded so data falls through
  always_comb begin
    push_word = {push_ferr, perr_q, shift_q};
    pop_ok    = Rx_RD && !empty_q;
    push_ok   = push && (!full_q || pop_ok);
    wr_d      = push_ok ? wr_q + 1'b1 : wr_q;
    rd_d      = pop_ok ? rd_q + 1'b1 : rd_q;
    ovr_d     = ovr_q | (push && full_q && !pop_ok);
    empty_d   = (wr_d == rd_d);
    full_d    = (wr_d[AW-1:0] == rd_d[AW-1:0]) && (wr_d[AW] != rd_d[AW]);
    head_d    = head_q;
    // The new head may be the word being written on this same edge
    if (!empty_d) begin
      if (push_ok && (rd_d == wr_q)) head_d = push_word;
      else                           head_d = mem_q[rd_d[AW-1:0]];
    end
  end

  // FIFO control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovr_q   <= 1'b0;
      head_q  <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ovr_q   <= ovr_d;
      head_q  <= head_d;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= push_word;
  end

  assign Rx_DATA    = head_q[7:0];
  assign Rx_PERROR  = head_q[8];
  assign Rx_FERROR  = head_q[9];
  assign Rx_EMPTY   = empty_q;
  assign Rx_FULL    = full_q;
  assign Rx_OVERRUN = ovr_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed frames against uart_rx_fifo with hand-computed
// expectations. CLK_HZ=921600 gives DIV=1 at 115200, 6 at 9600, 192 at 300.
module tb_uart_rx_fifo;
  logic       clk, reset, Rx_EN, RxD, Rx_RD;
  logic [2:0] baud_select;
  logic [7:0] Rx_DATA;
  logic       Rx_FERROR, Rx_PERROR, Rx_EMPTY, Rx_FULL, Rx_OVERRUN;
  logic [9:0] head;
  int         checks = 0;
  int         errors = 0;

  localparam int unsigned BIT7 = 16;    // 115200: 16 ticks of 1 cycle
  localparam int unsigned BIT3 = 96;    // 9600:   16 ticks of 6 cycles
  localparam int unsigned BIT0 = 3072;  // 300:    16 ticks of 192 cycles

  uart_rx_fifo #(.CLK_HZ(921600), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .baud_select(baud_select), .Rx_EN(Rx_EN),
    .RxD(RxD), .Rx_RD(Rx_RD), .Rx_DATA(Rx_DATA), .Rx_FERROR(Rx_FERROR),
    .Rx_PERROR(Rx_PERROR), .Rx_EMPTY(Rx_EMPTY), .Rx_FULL(Rx_FULL),
    .Rx_OVERRUN(Rx_OVERRUN)
  );

  assign head = {Rx_FERROR, Rx_PERROR, Rx_DATA};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives the first nbits of {stop, parity, data, start}; call on a negedge.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int unsigned bc, input int unsigned nbits);
    logic [10:0] f;
    f = {stp, par, d, 1'b0};
    for (int unsigned i = 0; i < nbits; i++) begin
      RxD = f[i];
      repeat (bc) @(negedge clk);
    end
  endtask

  task automatic send_ok(input logic [7:0] d, input int unsigned bc);
    send_frame(d, ^d, 1'b1, bc, 11);
  endtask

  // Full frame at 115200 with Rx_RD high across the push edge (172 cycles in)
  task automatic send_rd(input logic [7:0] d);
    fork
      send_ok(d, BIT7);
      begin
        repeat (172) @(negedge clk);
        Rx_RD = 1'b1;
        @(negedge clk);
        Rx_RD = 1'b0;
      end
    join
  endtask

  task automatic pop();
    Rx_RD = 1'b1;
    @(negedge clk);
    Rx_RD = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_data"}, {22'd0, head}, 32'h0);
    check({tag, "_empty"}, {31'd0, Rx_EMPTY}, 32'd1);
    check({tag, "_full"}, {31'd0, Rx_FULL}, 32'd0);
    check({tag, "_ovr"}, {31'd0, Rx_OVERRUN}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    clk = 1'b0; reset = 1'b1; Rx_EN = 1'b1; RxD = 1'b1; Rx_RD = 1'b0;
    baud_select = 3'd7;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_vals("reset");
    repeat (5) @(negedge clk);

    // Clean 0xA5; push lands 3 sync/detect cycles + 10 ticks into the stop bit
    send_frame(8'hA5, 1'b0, 1'b1, BIT7, 10);
    RxD = 1'b1;
    cnt = 0;
    while (Rx_EMPTY && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("empty_latency", cnt, 13);
    check("clean_head", {22'd0, head}, 32'h0A5);
    repeat (8) @(negedge clk);
    pop();
    check("clean_pop_empty", {31'd0, Rx_EMPTY}, 32'd1);

    // Parity error then framing error
    send_frame(8'h01, 1'b0, 1'b1, BIT7, 11);
    send_frame(8'h3C, 1'b0, 1'b0, BIT7, 11);
    RxD = 1'b1;
    repeat (20) @(negedge clk);
    check("perr_head", {22'd0, head}, 32'h101);
    pop();
    check("ferr_head", {22'd0, head}, 32'h23C);

    // 5-cycle glitch (5 ticks at DIV=1) must be rejected
    RxD = 1'b0;
    repeat (5) @(negedge clk);
    RxD = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_head", {22'd0, head}, 32'h23C);
    check("glitch_ovr", {31'd0, Rx_OVERRUN}, 32'd0);

    // Enable dropped mid-frame; pop still works with enable low
    send_frame(8'h00, 1'b0, 1'b1, BIT7, 4);
    Rx_EN = 1'b0;
    repeat (20) @(negedge clk);
    RxD = 1'b1;
    repeat (20) @(negedge clk);
    check("en_drop_head", {22'd0, head}, 32'h23C);
    pop();
    check("en_drop_empty", {31'd0, Rx_EMPTY}, 32'd1);
    Rx_EN = 1'b1;
    repeat (5) @(negedge clk);

    // Pop on push edge while empty: only the push takes effect
    send_rd(8'h10);
    check("rd_empty_push", {31'd0, Rx_EMPTY}, 32'd0);
    check("rd_empty_head", {22'd0, head}, 32'h010);
    send_ok(8'h11, BIT7);
    send_ok(8'h12, BIT7);
    send_ok(8'h13, BIT7);
    check("fill_full", {31'd0, Rx_FULL}, 32'd1);
    check("fill_no_ovr", {31'd0, Rx_OVERRUN}, 32'd0);
    // Pop on push edge while full: both happen, no overrun
    send_rd(8'h14);
    check("rd_full_full", {31'd0, Rx_FULL}, 32'd1);
    check("rd_full_ovr", {31'd0, Rx_OVERRUN}, 32'd0);
    check("rd_full_head", {22'd0, head}, 32'h011);
    send_ok(8'h15, BIT7);
    check("ovr_set", {31'd0, Rx_OVERRUN}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d", i), {22'd0, head}, 32'h011 + i);
      pop();
      check($sformatf("drain_full%0d", i), {31'd0, Rx_FULL}, 32'd0);
    end
    check("drain_empty", {31'd0, Rx_EMPTY}, 32'd1);
    check("ovr_sticky", {31'd0, Rx_OVERRUN}, 32'd1);

    // Baud sweep: 300 baud, then 9600 nominal, -3% and +3% back-to-back
    baud_select = 3'd0;
    repeat (5) @(negedge clk);
    send_ok(8'h55, BIT0);
    repeat (50) @(negedge clk);
    check("b300_head", {22'd0, head}, 32'h055);
    pop();
    baud_select = 3'd3;
    repeat (5) @(negedge clk);
    send_ok(8'h55, BIT3);
    send_ok(8'h55, BIT3);
    send_ok(8'h55, 93);
    send_ok(8'h55, 99);
    repeat (50) @(negedge clk);
    check("b9600_full", {31'd0, Rx_FULL}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b9600_%0d", i), {22'd0, head}, 32'h055);
      pop();
    end
    check("b9600_empty", {31'd0, Rx_EMPTY}, 32'd1);

    // Reset during DATA with two entries queued
    baud_select = 3'd7;
    repeat (5) @(negedge clk);
    send_ok(8'h21, BIT7);
    send_ok(8'h22, BIT7);
    check("pre_reset_head", {22'd0, head}, 32'h021);
    send_frame(8'h33, 1'b0, 1'b1, BIT7, 3);
    reset = 1'b1;
    RxD = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_vals("midreset");
    repeat (20) @(negedge clk);
    send_ok(8'h7E, BIT7);
    repeat (5) @(negedge clk);
    check("post_reset_head", {22'd0, head}, 32'h07E);
    check("post_reset_empty", {31'd0, Rx_EMPTY}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Standalone UART receive path with 16x oversampling and a small receive FIFO; it is the far end of the serial link driven by the team's UART transmitter (8 data bits, even parity, 1 stop bit, same `baud_select` encoding). It recovers frames from `RxD`, flags framing and parity errors per word, and buffers received words so the user logic can read them at its own pace. It replaces direct single-word capture wherever back-to-back frames must not be lost.

## Interface

**Parameters**
- `CLK_HZ`, default 50_000_000: system clock frequency in Hz.
- `DEPTH`, default 4: FIFO entries; must be a power of 2, minimum 2.

**Ports**
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `baud_select` in 3: baud rate code. 000=300, 001=1200, 010=4800, 011=9600, 100=19200, 101=38400, 110=57600, 111=115200.
- `Rx_EN` in 1: receiver enable.
- `RxD` in 1: serial input, asynchronous, idles high.
- `Rx_RD` in 1: single-cycle pop request for the head word.
- `Rx_DATA` out 8: head word data.
- `Rx_FERROR` out 1: head word had stop bit = 0.
- `Rx_PERROR` out 1: head word failed the even-parity check.
- `Rx_EMPTY` out 1: FIFO empty.
- `Rx_FULL` out 1: FIFO full.
- `Rx_OVERRUN` out 1: sticky flag; a completed frame was dropped.

## Operation

**Input synchronisation**
- `RxD` passes through a 2-flop synchroniser.
- All decoding uses the synchronised value.

**Sample tick**
- Divider `DIV = round(CLK_HZ/(16*baud))`. At 50 MHz: 10417, 2604, 651, 326, 163, 81, 54, 27.
- The counter is held at 0 in IDLE and starts on start-edge detection.
- One tick is issued every `DIV` cycles.
- `baud_select` is sampled only in IDLE.

**FSM states**
- IDLE
  - Wait for synchronised `RxD` to go from 1 to 0 while `Rx_EN`=1.
  - Then go to START with the tick index at 0.
- START
  - Take samples at ticks 7, 8 and 9; the bit value is the majority of the three.
  - Majority 1 means a false start: return to IDLE and raise no flags.
  - Otherwise, at tick 15, go to DATA.
- DATA
  - 8 bits, 16 ticks each, majority sampled at ticks 7/8/9.
  - Shift in LSB first.
- PARITY
  - 1 bit, sampled the same way.
  - `perr = ^data ^ parity_bit` (even parity).
- STOP
  - Majority sample at ticks 7/8/9; `ferr = !stop`.
  - At tick 9, push `{ferr, perr, data}` and go to IDLE.
  - A new start edge is accepted from the next cycle, so the remaining half stop bit is not waited out.

**Enable**
- `Rx_EN`=0 forces IDLE and abandons any partial frame with no push.
- FIFO contents stay readable and `Rx_RD` still works.

**FIFO**
- First-word-fall-through: `Rx_DATA`, `Rx_FERROR` and `Rx_PERROR` show the head entry whenever `Rx_EMPTY`=0.
- When empty, these outputs hold their last value.
- Read and write pointers are `log2(DEPTH)+1` bits wide and wrap modulo `2*DEPTH`.
- `Rx_EMPTY` is asserted when the pointers are equal.
- `Rx_FULL` is asserted when the index bits are equal and the MSBs differ.
- `Rx_RD` while empty is ignored; pointers are unchanged.
- Push while full with no pop: the word is dropped and `Rx_OVERRUN` is set to 1.
- Push and pop in the same cycle while full: both happen, no overrun.
- Push and pop in the same cycle while empty: only the push happens.
- `Rx_OVERRUN` clears only on `reset`.

## Timing

**Reset values**
- `Rx_DATA`=0, `Rx_FERROR`=0, `Rx_PERROR`=0.
- `Rx_EMPTY`=1, `Rx_FULL`=0, `Rx_OVERRUN`=0.
- FSM in IDLE, pointers at 0, divider at 0.
- `reset` mid-frame discards the frame and empties the FIFO on the same edge.

**Latency**
- Start edge detection comes 2 cycles after the `RxD` fall, due to the synchroniser.
- The push happens on the clock edge of stop-bit tick 9.
- `Rx_EMPTY` falls, and the head outputs become valid, on the edge after the push.
- A pop on edge N updates the head outputs and flags after edge N, so they are visible in cycle N+1.
- `Rx_FULL` and `Rx_EMPTY` are registered and reflect the pointer state after each edge.

**Frame length**
- A frame lasts 11 bit times. At 115200 baud with a 50 MHz clock, that is 11 × 16 × 27 = 4752 cycles per frame.

## Test plan

- **Clean frame:** at 115200, send 0xA5 with parity 0 and stop 1 → one entry with `Rx_DATA`=0xA5 and both error flags 0. `Rx_EMPTY` falls within 2 cycles of stop tick 9. `Rx_RD` returns `Rx_EMPTY` to 1.
- **Error flags:** send 0x01 with parity 0, then 0x3C with stop 0 → first entry has `Rx_PERROR`=1; second entry has `Rx_FERROR`=1 and `Rx_DATA`=0x3C.
- **Glitch and enable:** a 5-tick low pulse on `RxD` → no push. Drop `Rx_EN` mid-frame → no push, FIFO contents unchanged.
- **Fill and overrun:** send 5 frames 0x10..0x14 with no reads (`DEPTH`=4) → `Rx_FULL`=1, `Rx_OVERRUN`=1, and reads return 0x10..0x13. Pulse `Rx_RD` on the exact push cycle when full → no overrun.
- **Baud sweep:** send 0x55 back-to-back at codes 000 and 011 → correct data. Repeat with the stimulus bit period skewed ±3% → still correct.
- **Reset mid-frame:** assert `reset` during DATA with 2 entries queued → all outputs at reset values on the next cycle. The following frame is received normally.
